decision_stack: RTL and testbench
=================================

Name: decision_stack

Overview:
- LIFO assignment trail for the DPLL/CDCL SAT engine; each entry records one variable assignment: variable index, value and assignment type (decision or forced/implied).
- Sits between the decision/propagation logic (pushes) and the backtrack controller (pops).
- Exposes the current top entry combinationally, plus empty/full status.

Parameters:
- VAR_W, default `MAX_VARS_BITS (from sysdefs.svh), width of the variable index.
- DEPTH, default 2**`MAX_VARS_BITS, number of entries; must be >= 2.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  write {type_in,val_in,var_in} as the new top entry.
- pop  in  1  remove the top entry.
- type_in  in  1  0 = decision, 1 = forced (implied).
- val_in  in  1  assigned truth value.
- var_in  in  VAR_W  variable index.
- var_out  out  VAR_W  variable index of the current top entry.
- type_out  out  1  type of the current top entry.
- val_out  out  1  value of the current top entry.
- empty  out  1  high when the stack holds 0 entries.
- full  out  1  high when the stack holds DEPTH entries.

Behaviour:
- Storage: DEPTH x (VAR_W+2) register array; count register sp, $clog2(DEPTH+1) bits, equal to the number of valid entries.
- Reset (asynchronous, any time, including mid-operation): sp <= 0. Array contents are not cleared. Outputs immediately read var_out=0, type_out=0, val_out=0, empty=1, full=0.
- Outputs are combinational from state: when sp>0, {type_out,val_out,var_out} = mem[sp-1]; when sp==0, all zero. empty = (sp==0); full = (sp==DEPTH).
- Push only, not full: mem[sp] <= inputs; sp <= sp+1. The new entry appears on the outputs in the cycle after the edge (1-cycle latency).
- Push only, full: ignored; no state change.
- Pop only, not empty: sp <= sp-1. Outputs show the new top, or zeros if the stack is now empty.
- Pop only, empty: ignored; sp stays 0.
- Push and pop in the same cycle, not empty: replace the top entry: mem[sp-1] <= inputs; sp unchanged. This holds even when full.
- Push and pop in the same cycle, empty: behaves as a plain push.
- Neither asserted: hold.
- No wrap-around: sp saturates logically at 0 and DEPTH through the ignore rules above.

Optional Feature:
- Macro STACK_ERR_FLAG_EN.
- Defined: adds output port err (1 bit), a sticky flag set on any ignored operation (push-only while full, or pop-only while empty). err is cleared only by reset and has a reset value of 0.
- Undefined: the port and its logic are absent; ignored operations are silent.

Decomposition:
- Shared package (e.g. sat_pkg): typedef enum logic {ASSIGN_DECIDE=1'b0, ASSIGN_FORCED=1'b1}; packed struct trail_entry_t {type, val, var[VAR_W-1:0]}; the VAR_W constant derived from `MAX_VARS_BITS.
- Single module; no sub-module needed. The storage array is inline.

Test Plan:
- Reset held 1 cycle -> empty=1, full=0, var_out=0, type_out=0, val_out=0. Then pop on empty -> no change, empty stays 1 (err=1 if STACK_ERR_FLAG_EN).
- Push {type=1,val=1,var=69} -> next cycle var_out=69, type_out=1, val_out=1, empty=0. Then pop -> empty=1, outputs 0.
- Push {0,0,12} then {1,1,13} -> top 13/1/1. Pop -> top 12/0/0. Pop -> empty=1.
- Push 14/1/1, 15/0/0, 16/1/0, 17/0/1 (type/val) -> tops in order 14,15,16,17. Four pops -> tops 16,15,14, then empty with outputs 0.
- Fill DEPTH entries -> full=1. Extra push -> ignored, top unchanged. Push+pop with var=5 -> top replaced with 5, full stays 1.
- Assert reset asynchronously mid-clock with 3 entries -> empty=1 and outputs 0 before the next posedge.

Source files
------------

// File: rtl/decision_stack_pkg.sv
// Shared types for the SAT engine assignment trail.
// VAR_W derives from MAX_VARS_BITS, which normally comes from the system
// definitions; a local fallback keeps this slice self-contained.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 7
`endif

package decision_stack_pkg;

  localparam int STACK_VAR_W = `MAX_VARS_BITS;

  typedef enum logic {
    ASSIGN_DECIDE = 1'b0,
    ASSIGN_FORCED = 1'b1
  } assign_type_e;

  typedef struct packed {
    assign_type_e                 entry_type;
    logic                         val;
    logic [STACK_VAR_W-1:0]       var_idx;
  } trail_entry_t;

endpackage

// File: rtl/decision_stack.sv
// decision_stack: LIFO assignment trail between decision/propagation (push)
// and the backtrack controller (pop). The top entry and empty/full are
// combinational from state. Push+pop on a non-empty stack replaces the top.
// Optional build macro STACK_ERR_FLAG_EN adds a sticky 'err' output that
// flags ignored operations (push-only while full, pop-only while empty).
// DEPTH must be >= 2.
module decision_stack
  import decision_stack_pkg::*;
#(
  parameter int VAR_W = STACK_VAR_W,
  parameter int DEPTH = 2**STACK_VAR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             type_in,
  input  logic             val_in,
  input  logic [VAR_W-1:0] var_in,
  output logic [VAR_W-1:0] var_out,
  output logic             type_out,
  output logic             val_out,
  output logic             empty,
  output logic             full
`ifdef STACK_ERR_FLAG_EN
  ,
  output logic             err
`endif
);

  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    assign_type_e     entry_type;
    logic             val;
    logic [VAR_W-1:0] var_idx;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic            empty_w, full_w;
  entry_t          wr_entry;
  entry_t          top_entry;

  assign empty_w = (sp_q == '0);
  assign full_w  = (sp_q == SP_W'(DEPTH));
  assign rd_addr = AW'(sp_q - SP_W'(1));

  assign wr_entry.entry_type = assign_type_e'(type_in);
  assign wr_entry.val        = val_in;
  assign wr_entry.var_idx    = var_in;

  // Next stack pointer and write port from the push/pop combination.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    sp_d    = sp_q;
    wr_en   = 1'b0;
    wr_addr = AW'(sp_q);
    case ({push, pop})
      2'b10: begin
        if (!full_w) begin
          wr_en = 1'b1;
          sp_d  = sp_q + SP_W'(1);
        end
      end
      2'b01: begin
        if (!empty_w) sp_d = sp_q - SP_W'(1);
      end
      2'b11: begin
        wr_en = 1'b1;
        if (empty_w) begin
          sp_d = sp_q + SP_W'(1);
        end else begin
          wr_addr = rd_addr;
        end
      end
      default: ;
    endcase
  end

  // Stack pointer: the only state cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  // Entry storage.
  // NOTE: the array is deliberately not reset; sp alone defines which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_entry;
  end

  // Top-of-stack view; all zero when the stack is empty.
  always_comb begin
    top_entry = '0;
    if (!empty_w) top_entry = mem_q[rd_addr];
  end

  assign var_out  = top_entry.var_idx;
  assign type_out = top_entry.entry_type;
  assign val_out  = top_entry.val;
  assign empty    = empty_w;
  assign full     = full_w;

`ifdef STACK_ERR_FLAG_EN
  logic err_q;

  // Sticky flag for ignored operations; cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((push && !pop && full_w) || (pop && !push && empty_w)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_decision_stack.sv
// Self-checking bench for decision_stack: directed table, hand-written
// corner sequences (fill/overflow/replace, asynchronous reset) and a
// randomized run against a queue-based reference model.
module tb_decision_stack;
  import decision_stack_pkg::*;

  localparam int VAR_W = STACK_VAR_W;
  localparam int DEPTH = 8;

  logic             clock;
  logic             reset;
  logic             push, pop, type_in, val_in;
  logic [VAR_W-1:0] var_in;
  logic [VAR_W-1:0] var_out;
  logic             type_out, val_out, empty, full;
`ifdef STACK_ERR_FLAG_EN
  logic             err;
`endif

  decision_stack #(.VAR_W(VAR_W), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .type_in (type_in),
    .val_in  (val_in),
    .var_in  (var_in),
    .var_out (var_out),
    .type_out(type_out),
    .val_out (val_out),
    .empty   (empty),
    .full    (full)
`ifdef STACK_ERR_FLAG_EN
    ,
    .err     (err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_top(input string tag, input logic e_empty, input logic e_full,
                           input logic e_type, input logic e_val, input logic [VAR_W-1:0] e_var);
    check({tag, ".empty"}, 32'(empty), 32'(e_empty));
    check({tag, ".full"},  32'(full),  32'(e_full));
    check({tag, ".type"},  32'(type_out), 32'(e_type));
    check({tag, ".val"},   32'(val_out),  32'(e_val));
    check({tag, ".var"},   32'(var_out),  32'(e_var));
  endtask

  // One clock of stimulus; inputs change 1 time unit after the edge.
  task automatic step(input logic p, input logic o, input logic t, input logic v,
                      input logic [VAR_W-1:0] x);
    push = p; pop = o; type_in = t; val_in = v; var_in = x;
    @(posedge clock);
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Reference model: the trail as a queue, top at the back.
  trail_entry_t model_q[$];
  logic         model_err;

  task automatic model_apply(input logic p, input logic o, input trail_entry_t e);
    if (p && !o) begin
      if (model_q.size() < DEPTH) model_q.push_back(e);
      else model_err = 1'b1;
    end else if (o && !p) begin
      if (model_q.size() > 0) void'(model_q.pop_back());
      else model_err = 1'b1;
    end else if (p && o) begin
      if (model_q.size() == 0) model_q.push_back(e);
      else model_q[model_q.size()-1] = e;
    end
  endtask

  task automatic check_model(input string tag);
    trail_entry_t top;
    top = '0;
    if (model_q.size() > 0) top = model_q[model_q.size()-1];
    check_top(tag, model_q.size() == 0, model_q.size() == DEPTH,
              top.entry_type, top.val, top.var_idx);
`ifdef STACK_ERR_FLAG_EN
    check({tag, ".err"}, 32'(err), 32'(model_err));
`endif
  endtask

  typedef struct {
    logic             p, o, t, v;
    logic [VAR_W-1:0] x;
    logic             e_empty, e_full, e_type, e_val;
    logic [VAR_W-1:0] e_var;
  } vec_t;

  vec_t vecs[$];

  initial begin
    push = 0; pop = 0; type_in = 0; val_in = 0; var_in = '0;
    reset = 1'b0;
    #2;

    // Directed table: {push,pop,type,val,var} -> {empty,full,type,val,var}.
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,7'd0,  1'b1,1'b0,1'b0,1'b0,7'd0});
    vecs.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,7'd69, 1'b0,1'b0,1'b1,1'b1,7'd69});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,7'd0,  1'b1,1'b0,1'b0,1'b0,7'd0});
    vecs.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,7'd12, 1'b0,1'b0,1'b0,1'b0,7'd12});
    vecs.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,7'd13, 1'b0,1'b0,1'b1,1'b1,7'd13});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,7'd0,  1'b0,1'b0,1'b0,1'b0,7'd12});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,7'd0,  1'b1,1'b0,1'b0,1'b0,7'd0});
    vecs.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,7'd14, 1'b0,1'b0,1'b1,1'b1,7'd14});
    vecs.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,7'd15, 1'b0,1'b0,1'b0,1'b0,7'd15});
    vecs.push_back(vec_t'{1'b1,1'b0,1'b1,1'b0,7'd16, 1'b0,1'b0,1'b1,1'b0,7'd16});
    vecs.push_back(vec_t'{1'b1,1'b0,1'b0,1'b1,7'd17, 1'b0,1'b0,1'b0,1'b1,7'd17});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,7'd0,  1'b0,1'b0,1'b1,1'b0,7'd16});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,7'd0,  1'b0,1'b0,1'b0,1'b0,7'd15});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,7'd0,  1'b0,1'b0,1'b1,1'b1,7'd14});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,7'd0,  1'b1,1'b0,1'b0,1'b0,7'd0});
    vecs.push_back(vec_t'{1'b0,1'b0,1'b1,1'b1,7'd99, 1'b1,1'b0,1'b0,1'b0,7'd0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,1'b1,7'd33, 1'b0,1'b0,1'b0,1'b1,7'd33});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b1,1'b0,7'd34, 1'b0,1'b0,1'b1,1'b0,7'd34});
    vecs.push_back(vec_t'{1'b0,1'b0,1'b0,1'b0,7'd0,  1'b0,1'b0,1'b1,1'b0,7'd34});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,7'd0,  1'b1,1'b0,1'b0,1'b0,7'd0});

    // Reset state, checked while reset is held and after release.
    reset = 1'b1;
    #1;
    check_top("rst_held", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_top("rst_done", 1'b1, 1'b0, 1'b0, 1'b0, '0);
`ifdef STACK_ERR_FLAG_EN
    check("rst_done.err", 32'(err), 32'd0);
`endif

    foreach (vecs[i]) begin
      step(vecs[i].p, vecs[i].o, vecs[i].t, vecs[i].v, vecs[i].x);
      check_top($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full,
                vecs[i].e_type, vecs[i].e_val, vecs[i].e_var);
    end
`ifdef STACK_ERR_FLAG_EN
    check("table.err_sticky", 32'(err), 32'd1);
`endif

    // Fill to DEPTH, overflow push ignored, push+pop replaces top while full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, i[0], i[1], VAR_W'(40 + i));
      check("fill.var", 32'(var_out), 32'(40 + i));
      check("fill.full", 32'(full), 32'(i == DEPTH - 1));
    end
`ifdef STACK_ERR_FLAG_EN
    check("fill.err", 32'(err), 32'd0);
`endif
    step(1'b1, 1'b0, 1'b0, 1'b0, 7'd99);
    check_top("overflow", 1'b0, 1'b1, 1'b1, 1'b1, 7'd47);
`ifdef STACK_ERR_FLAG_EN
    check("overflow.err", 32'(err), 32'd1);
`endif
    step(1'b1, 1'b1, 1'b0, 1'b1, 7'd5);
    check_top("full_replace", 1'b0, 1'b1, 1'b0, 1'b1, 7'd5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
    check_top("pop_after_replace", 1'b0, 1'b0, 1'b0, 1'b1, 7'd46);

    // Asynchronous reset mid-cycle with three entries.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 7'd21);
    step(1'b1, 1'b0, 1'b0, 1'b1, 7'd22);
    step(1'b1, 1'b0, 1'b1, 1'b1, 7'd23);
    check_top("pre_async", 1'b0, 1'b0, 1'b1, 1'b1, 7'd23);
    #3;
    reset = 1'b1;
    #1;
    check_top("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_top("after_async", 1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Randomized run against the queue model: push-heavy, then pop-heavy.
    do_reset();
    model_q.delete();
    model_err = 1'b0;
    for (int n = 0; n < 600; n++) begin
      trail_entry_t e;
      logic p, o;
      int   p_pct;
      p_pct = (n < 300) ? 65 : 35;
      p = ($urandom_range(0, 99) < p_pct);
      o = ($urandom_range(0, 99) < (100 - p_pct));
      e.entry_type = assign_type_e'($urandom_range(0, 1));
      e.val        = 1'($urandom_range(0, 1));
      e.var_idx    = VAR_W'($urandom);
      step(p, o, e.entry_type, e.val, e.var_idx);
      model_apply(p, o, e);
      check_model($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
